// File: rtl/router_txn_checker_pkg.sv
// Shared types and constants for the router transaction checker.
package router_chk_pkg;

    localparam int CNT_W = 16;
    localparam int AGE_W = 8;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_BAD_ADDR   = 3'd1,
        ERR_OVERFLOW   = 3'd2,
        ERR_MISMATCH   = 3'd3,
        ERR_UNEXPECTED = 3'd4,
        ERR_TIMEOUT    = 3'd5
    } err_code_e;

    // Ages stop at all-ones so an abandoned slot never wraps back to a young age.
    function automatic logic [AGE_W-1:0] ageInc(input logic [AGE_W-1:0] age);
        return (age == {AGE_W{1'b1}}) ? age : age + AGE_W'(1);
    endfunction

endpackage

// File: rtl/router_txn_checker_if.sv
// Bus between the router under observation and the transaction checker.
interface router_txn_checker_if
    import router_chk_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8
);
    logic [NUM_PORTS-1:0]        valid_in;
    logic [NUM_PORTS*DATA_W-1:0] data_in;
    logic [NUM_PORTS*ADDR_W-1:0] addr_in;
    logic [NUM_PORTS-1:0]        valid_out;
    logic [NUM_PORTS*DATA_W-1:0] data_out;

    logic                        err_valid;
    logic [2:0]                  err_code;
    logic [7:0]                  err_port;
    logic [CNT_W-1:0]            match_count;
    logic [CNT_W-1:0]            err_count;
    logic [NUM_PORTS-1:0]        pending;

    modport master (
        output valid_in, data_in, addr_in, valid_out, data_out,
        input  err_valid, err_code, err_port, match_count, err_count, pending
    );

    modport slave (
        input  valid_in, data_in, addr_in, valid_out, data_out,
        output err_valid, err_code, err_port, match_count, err_count, pending
    );
endinterface

// File: rtl/router_txn_checker_exp_fifo.sv
// One output port's queue of expected payloads, each tagged with its age in cycles.
module chk_exp_fifo
    import router_chk_pkg::*;
#(
    parameter int NUM_PUSH = 4,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int MAX_LAT  = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_PUSH-1:0]        push_i,
    input  logic [NUM_PUSH*DATA_W-1:0] push_data_i,
    input  logic                       pop_i,
    output logic [NUM_PUSH-1:0]        drop_full_o,
    output logic [DATA_W-1:0]          head_data_o,
    output logic                       empty_o,
    output logic                       head_timeout_o
);
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [AGE_W-1:0] LAST_AGE = AGE_W'(MAX_LAT - 1);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [AGE_W-1:0]  age_q  [DEPTH];
    logic [AGE_W-1:0]  age_d  [DEPTH];
    logic [FILL_W-1:0] count_q, count_d, fill;

    // Pop shifts toward slot 0, then pushes append in input-port order until the queue is full.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
            age_d[i]  = ageInc(age_q[i]);
        end
        fill        = count_q;
        drop_full_o = '0;
        if (pop_i && count_q != '0) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                data_d[i] = data_q[i+1];
                age_d[i]  = ageInc(age_q[i+1]);
            end
            fill = fill - FILL_W'(1);
        end
        for (int p = 0; p < NUM_PUSH; p++) begin
            if (push_i[p]) begin
                if (fill < FILL_W'(DEPTH)) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (FILL_W'(i) == fill) begin
                            data_d[i] = push_data_i[p*DATA_W +: DATA_W];
                            age_d[i]  = '0;
                        end
                    end
                    fill = fill + FILL_W'(1);
                end else begin
                    drop_full_o[p] = 1'b1;
                end
            end
        end
        count_d = fill;
    end

    // Queue contents and fill level; reset discards every outstanding expectation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end

    assign empty_o        = (count_q == '0);
    assign head_data_o    = data_q[0];
    assign head_timeout_o = !empty_o && (age_q[0] >= LAST_AGE);

endmodule

// File: rtl/router_txn_checker.sv
// Scoreboard that predicts router outputs from its inputs and reports delivery errors.
module router_txn_checker
    import router_chk_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 4,
    parameter int MAX_LAT   = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    router_txn_checker_if.slave chk_if
);
    localparam logic [31:0] SAT_MAX = 32'((1 << CNT_W) - 1);

    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] pushSel;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] fifoDrop;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    fifoHead;
    logic [NUM_PORTS-1:0]                fifoEmpty, fifoTimeout, popReq;

    logic [NUM_PORTS-1:0] evBad, evOverflow, evUnexp, evMismatch, evTimeout, evMatch;
    int unsigned          errEvents, matchEvents;
    logic [31:0]          errSum, matchSum;

    err_code_e        errCode_q, errCode_d;
    logic [7:0]       errPort_q, errPort_d;
    logic             errValid_q, errValid_d;
    logic [CNT_W-1:0] errCount_q, errCount_d, matchCount_q, matchCount_d;

    // Route each valid input byte to the queue named by its destination address.
    always_comb begin
        pushSel = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pushSel[o][p] = chk_if.valid_in[p] &&
                                (chk_if.addr_in[p*ADDR_W +: ADDR_W] == ADDR_W'(o));
            end
        end
    end

    // A head leaves its queue when an output is compared against it or when it expires.
    always_comb begin
        popReq = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            popReq[o] = (chk_if.valid_out[o] && !fifoEmpty[o]) || fifoTimeout[o];
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        chk_exp_fifo #(
            .NUM_PUSH (NUM_PORTS),
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .MAX_LAT  (MAX_LAT)
        ) u_fifo (
            .clk            (clk),
            .reset_n        (reset_n),
            .push_i         (pushSel[o]),
            .push_data_i    (chk_if.data_in),
            .pop_i          (popReq[o]),
            .drop_full_o    (fifoDrop[o]),
            .head_data_o    (fifoHead[o]),
            .empty_o        (fifoEmpty[o]),
            .head_timeout_o (fifoTimeout[o])
        );
    end

    // Classify this cycle's events, count them, and pick the one to report.
    always_comb begin
        errEvents   = 0;
        matchEvents = 0;
        evBad       = '0;
        evOverflow  = '0;
        evUnexp     = '0;
        evMismatch  = '0;
        evTimeout   = '0;
        evMatch     = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            evBad[p] = chk_if.valid_in[p] &&
                       (chk_if.addr_in[p*ADDR_W +: ADDR_W] >= ADDR_W'(NUM_PORTS));
            if (evBad[p]) errEvents++;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            evTimeout[o]  = fifoTimeout[o] && !chk_if.valid_out[o];
            evUnexp[o]    = chk_if.valid_out[o] && fifoEmpty[o];
            evMatch[o]    = chk_if.valid_out[o] && !fifoEmpty[o] &&
                            (fifoHead[o] == chk_if.data_out[o*DATA_W +: DATA_W]);
            evMismatch[o] = chk_if.valid_out[o] && !fifoEmpty[o] && !evMatch[o];
            evOverflow[o] = |fifoDrop[o];
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (fifoDrop[o][p]) errEvents++;
            end
            if (evTimeout[o])  errEvents++;
            if (evUnexp[o])    errEvents++;
            if (evMismatch[o]) errEvents++;
            if (evMatch[o])    matchEvents++;
        end

        errCode_d = ERR_NONE;
        errPort_d = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (evBad[i]) begin errCode_d = ERR_BAD_ADDR; errPort_d = 8'(i); end
        end
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (evOverflow[i]) begin errCode_d = ERR_OVERFLOW; errPort_d = 8'(i); end
        end
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (evUnexp[i]) begin errCode_d = ERR_UNEXPECTED; errPort_d = 8'(i); end
        end
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (evMismatch[i]) begin errCode_d = ERR_MISMATCH; errPort_d = 8'(i); end
        end
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (evTimeout[i]) begin errCode_d = ERR_TIMEOUT; errPort_d = 8'(i); end
        end
        errValid_d = (errCode_d != ERR_NONE);

        errSum       = 32'(errCount_q) + errEvents;
        matchSum     = 32'(matchCount_q) + matchEvents;
        errCount_d   = (errSum > SAT_MAX) ? '1 : errSum[CNT_W-1:0];
        matchCount_d = (matchSum > SAT_MAX) ? '1 : matchSum[CNT_W-1:0];
    end

    // Error report lags detection by one cycle; counters saturate at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            errValid_q   <= 1'b0;
            errCode_q    <= ERR_NONE;
            errPort_q    <= '0;
            errCount_q   <= '0;
            matchCount_q <= '0;
        end else begin
            errValid_q   <= errValid_d;
            errCode_q    <= errCode_d;
            errPort_q    <= errPort_d;
            errCount_q   <= errCount_d;
            matchCount_q <= matchCount_d;
        end
    end

    assign chk_if.err_valid   = errValid_q;
    assign chk_if.err_code    = errCode_q;
    assign chk_if.err_port    = errPort_q;
    assign chk_if.err_count   = errCount_q;
    assign chk_if.match_count = matchCount_q;
    assign chk_if.pending     = ~fifoEmpty;

endmodule

// File: tb/tb_router_txn_checker.sv
// Directed bench for router_txn_checker with hand-computed expectations.
module tb_router_txn_checker;

    logic clk = 1'b0;
    logic reset_n;
    int   assertCount = 0;
    int   failCount   = 0;

    router_txn_checker_if #(.NUM_PORTS(4), .DATA_W(8), .ADDR_W(8)) bus ();

    router_txn_checker #(
        .NUM_PORTS (4),
        .DATA_W    (8),
        .ADDR_W    (8),
        .DEPTH     (4),
        .MAX_LAT   (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .chk_if  (bus)
    );

    always #5 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then step just past the next rising edge.
    task automatic applyStimulus(input logic [3:0] vin, input logic [31:0] addrVec,
                                 input logic [31:0] dataVec, input logic [3:0] vout,
                                 input logic [31:0] doutVec);
        bus.valid_in  = vin;
        bus.addr_in   = addrVec;
        bus.data_in   = dataVec;
        bus.valid_out = vout;
        bus.data_out  = doutVec;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(4'b0, 32'h0, 32'h0, 4'b0, 32'h0);
    endtask

    // Safety net in case the sequence below ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        bus.valid_in  = '0;
        bus.addr_in   = '0;
        bus.data_in   = '0;
        bus.valid_out = '0;
        bus.data_out  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_match_count", bus.match_count, 0);
        checkOutput("rst_err_count", bus.err_count, 0);
        checkOutput("rst_pending", bus.pending, 0);
        checkOutput("rst_err_valid", bus.err_valid, 0);
        checkOutput("rst_err_code", bus.err_code, 0);
        reset_n = 1'b1;

        // Correct delivery three cycles after injection.
        applyStimulus(4'b0001, 32'h0000_0002, 32'h0000_00A5, 4'b0000, 32'h0);
        checkOutput("t1_pending", bus.pending, 4'b0100);
        idleCycle();
        idleCycle();
        applyStimulus(4'b0000, 32'h0, 32'h0, 4'b0100, 32'h00A5_0000);
        checkOutput("t1_match_count", bus.match_count, 1);
        checkOutput("t1_err_valid", bus.err_valid, 0);
        checkOutput("t1_err_code", bus.err_code, 0);
        checkOutput("t1_pending", bus.pending, 0);

        // Corrupted payload on output 0.
        applyStimulus(4'b0010, 32'h0000_0000, 32'h0000_3C00, 4'b0000, 32'h0);
        applyStimulus(4'b0000, 32'h0, 32'h0, 4'b0001, 32'h0000_003D);
        checkOutput("t2_err_valid", bus.err_valid, 1);
        checkOutput("t2_err_code", bus.err_code, 3);
        checkOutput("t2_err_port", bus.err_port, 0);
        checkOutput("t2_err_count", bus.err_count, 1);
        checkOutput("t2_pending", bus.pending, 0);
        idleCycle();
        checkOutput("t2_pulse_valid", bus.err_valid, 0);
        checkOutput("t2_pulse_code", bus.err_code, 0);

        // Packet to output 1 that never appears.
        applyStimulus(4'b1000, 32'h0100_0000, 32'h7700_0000, 4'b0000, 32'h0);
        for (int k = 0; k < 7; k++) idleCycle();
        checkOutput("t3_early_valid", bus.err_valid, 0);
        checkOutput("t3_early_pending", bus.pending[1], 1);
        idleCycle();
        checkOutput("t3_err_valid", bus.err_valid, 1);
        checkOutput("t3_err_code", bus.err_code, 5);
        checkOutput("t3_err_port", bus.err_port, 1);
        checkOutput("t3_pending", bus.pending[1], 0);
        checkOutput("t3_err_count", bus.err_count, 2);

        // Four inputs hit output 3 on two cycles; second wave is dropped.
        applyStimulus(4'b1111, 32'h0303_0303, 32'h1312_1110, 4'b0000, 32'h0);
        checkOutput("t4_first_valid", bus.err_valid, 0);
        checkOutput("t4_first_pending", bus.pending, 4'b1000);
        applyStimulus(4'b1111, 32'h0303_0303, 32'h2322_2120, 4'b0000, 32'h0);
        checkOutput("t4_err_valid", bus.err_valid, 1);
        checkOutput("t4_err_code", bus.err_code, 2);
        checkOutput("t4_err_port", bus.err_port, 3);
        checkOutput("t4_err_count", bus.err_count, 6);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0000, 32'h0, 32'h0, 4'b1000, {8'(8'h10 + k), 24'h0});
            checkOutput("t4_order_valid", bus.err_valid, 0);
            checkOutput("t4_order_match", bus.match_count, 32'(2 + k));
        end
        checkOutput("t4_pending", bus.pending, 0);

        // Bad address, unexpected output, then both together.
        applyStimulus(4'b0100, 32'h0007_0000, 32'h0055_0000, 4'b0000, 32'h0);
        checkOutput("t5_bad_code", bus.err_code, 1);
        checkOutput("t5_bad_port", bus.err_port, 2);
        checkOutput("t5_bad_count", bus.err_count, 7);
        checkOutput("t5_bad_pending", bus.pending, 0);
        applyStimulus(4'b0000, 32'h0, 32'h0, 4'b0010, 32'h0000_1100);
        checkOutput("t5_unexp_code", bus.err_code, 4);
        checkOutput("t5_unexp_port", bus.err_port, 1);
        checkOutput("t5_unexp_count", bus.err_count, 8);
        applyStimulus(4'b0100, 32'h0007_0000, 32'h0055_0000, 4'b0110, 32'h0);
        checkOutput("t5_prio_code", bus.err_code, 4);
        checkOutput("t5_prio_port", bus.err_port, 1);
        checkOutput("t5_prio_count", bus.err_count, 11);

        // Full queue with a pop accepts exactly one new push.
        applyStimulus(4'b1111, 32'h0000_0000, 32'h4443_4241, 4'b0000, 32'h0);
        applyStimulus(4'b0001, 32'h0000_0000, 32'h0000_0050, 4'b0001, 32'h0000_0041);
        checkOutput("t6_swap_valid", bus.err_valid, 0);
        checkOutput("t6_swap_match", bus.match_count, 6);
        checkOutput("t6_swap_pending", bus.pending, 4'b0001);
        applyStimulus(4'b0011, 32'h0000_0000, 32'h0000_6160, 4'b0001, 32'h0000_0042);
        checkOutput("t6_ovf_code", bus.err_code, 2);
        checkOutput("t6_ovf_port", bus.err_port, 0);
        checkOutput("t6_ovf_count", bus.err_count, 12);
        checkOutput("t6_ovf_match", bus.match_count, 7);

        // Reset with four expectations outstanding.
        reset_n = 1'b0;
        #1;
        checkOutput("t7_match_count", bus.match_count, 0);
        checkOutput("t7_err_count", bus.err_count, 0);
        checkOutput("t7_pending", bus.pending, 0);
        checkOutput("t7_err_valid", bus.err_valid, 0);
        checkOutput("t7_err_code", bus.err_code, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(4'b0001, 32'h0000_0001, 32'h0000_0099, 4'b0000, 32'h0);
        checkOutput("t7_first_push", bus.pending, 4'b0010);
        applyStimulus(4'b0000, 32'h0, 32'h0, 4'b0010, 32'h0000_9900);
        checkOutput("t7_first_match", bus.match_count, 1);
        for (int k = 0; k < 10; k++) begin
            idleCycle();
            checkOutput("t7_quiet_valid", bus.err_valid, 0);
        end
        checkOutput("t7_quiet_count", bus.err_count, 0);
        checkOutput("t7_quiet_pending", bus.pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/router_txn_checker.md
ROUTER_TXN_CHECKER -- requirements
Module: router_txn_checker

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of router input and output ports.
REQ-002 Parameter DATA_W, default 8: payload width per port.
REQ-003 Parameter ADDR_W, default 8: destination address width per port.
REQ-004 Parameter DEPTH, default 4: outstanding expectations held per output port.
REQ-005 Parameter MAX_LAT, default 8: latency window in cycles (1..255).
REQ-006 clk  input  1  sole clock; all state on posedge clk.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 valid_in  input  NUM_PORTS  per-input-port packet byte valid.
REQ-009 data_in  input  NUM_PORTS*DATA_W  port p payload at [p*DATA_W +: DATA_W].
REQ-010 addr_in  input  NUM_PORTS*ADDR_W  port p destination at [p*ADDR_W +: ADDR_W].
REQ-011 valid_out  input  NUM_PORTS  per-output-port valid from DUT.
REQ-012 data_out  input  NUM_PORTS*DATA_W  DUT output payload, same slicing.
REQ-013 err_valid  output  1  one-cycle pulse: at least one error detected in previous cycle.
REQ-014 err_code  output  3  highest-priority error code of that cycle.
REQ-015 err_port  output  8  port index associated with the reported error.
REQ-016 match_count  output  16  saturating count of correct deliveries.
REQ-017 err_count  output  16  saturating count of all error events.
REQ-018 pending  output  NUM_PORTS  bit o = output o has at least one outstanding expectation.

Function
REQ-019 valid_in[p] with addr_in < NUM_PORTS SHALL push {data_in, age=0} into expectation queue addr_in in the same cycle's update.
REQ-020 Several inputs targeting one output in one cycle SHALL push in ascending input-port order.
REQ-021 valid_in[p] with addr_in >= NUM_PORTS SHALL raise BAD_ADDR (code 1, err_port=p); nothing pushed.
REQ-022 Push into a full queue SHALL raise OVERFLOW (code 2, err_port=output); entry dropped, others accepted.
REQ-023 valid_out[o] SHALL compare data_out against queue o head only (entries pushed in earlier cycles; min latency 1).
REQ-024 Equal: pop head, match_count += 1. Unequal: raise MISMATCH (code 3), pop head.
REQ-025 valid_out[o] with queue o empty SHALL raise UNEXPECTED (code 4).
REQ-026 All stored entries SHALL age by 1 per cycle; an unmatched head reaching age MAX_LAT SHALL raise TIMEOUT (code 5) and be popped.
REQ-027 Pop and push on the same queue in one cycle SHALL both take effect; full queue with pop accepts one push.
REQ-028 err_valid/err_code/err_port SHALL be registered, one cycle after detection.
REQ-029 Reporting priority: TIMEOUT > MISMATCH > UNEXPECTED > OVERFLOW > BAD_ADDR; ties to lowest port.
REQ-030 err_count SHALL add the total number of error events in a cycle, saturating at 16'hFFFF; match_count saturates likewise.
REQ-031 err_code 0 (NONE) SHALL be driven whenever err_valid is 0.

Reset
REQ-032 reset_n low SHALL clear all queues, ages, counters, pending, err_valid, err_code, err_port immediately.
REQ-033 Reset mid-operation SHALL discard outstanding expectations without raising TIMEOUT.
REQ-034 First push SHALL be accepted on the first clk edge after reset_n deasserts.

Structure
REQ-035 Package router_chk_pkg SHALL hold the err_code enum (NONE..TIMEOUT) and the counter width constant.
REQ-036 Sub-module chk_exp_fifo (one expectation queue with per-entry age, push/pop/full/empty/head_timeout) SHALL be instantiated NUM_PORTS times.

Verification
REQ-037 Port0 sends 8'hA5 to addr 2; output 2 valid with 8'hA5 three cycles later -> match_count=1, no err_valid.
REQ-038 Port1 sends 8'h3C to addr 0; output 0 presents 8'h3D -> err_valid, err_code=3, err_port=0, err_count=1.
REQ-039 Port3 sends to addr 1, no output for MAX_LAT=8 cycles -> TIMEOUT, err_port=1, pending[1]=0 afterwards.
REQ-040 Ports 0..3 all target addr 3 for two cycles with DEPTH=4, no pops -> 4 OVERFLOW events, err_count=4, head order 0,1,2,3.
REQ-041 valid_in[2] with addr 8'h07 -> BAD_ADDR, err_port=2; valid_out[1] with empty queue -> UNEXPECTED.
REQ-042 Three packets outstanding, reset_n pulsed low mid-window -> counters 0, pending 0, no TIMEOUT after release.
